// File: rtl/iwm_wr_serializer.sv
// IWM write serializer: holding register -> shift register -> flux-transition wrData, MSB first.
// Latency: first cell starts on the first cep after the holding register fills in WAIT; each byte is 8*BIT_CELL cep.
// Backpressure: _iwmBusy=0 while holding is full; later writes overwrite it (last write wins), empty at byte end = underrun.
// Optional: define IWM_WR_BYTE_COUNT_EN to add the byteCount[15:0] output (bytes completed this session).
module iwm_wr_serializer #(
    parameter int BIT_CELL = 16
) (
    input  logic        clk8,
    input  logic        _reset,
    input  logic        cep,
    input  logic        writeMode,
    input  logic        dataWrite,
    input  logic [7:0]  dataIn,
    output logic        _iwmBusy,
    output logic        _writeUnderrun,
    output logic        wrGate,
    output logic        wrData
`ifdef IWM_WR_BYTE_COUNT_EN
    ,
    output logic [15:0] byteCount
`endif
);

    localparam logic [7:0] CELL_LAST = 8'(BIT_CELL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        SHIFT    = 2'd2,
        UNDERRUN = 2'd3
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [7:0]  holdReg;
    logic        holdFull;
    logic [7:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic [7:0]  cellCnt;
    logic        wrDataR;

    logic        transfer;     // holding -> shift, starts a bit-7 cell
    logic        cellAdvance;  // end of cells 0..6: shift and start next cell
    logic        byteDone;     // end of the 8th cell
    logic        accept;       // CPU write lands in the holding register

    // The MSB is consumed on the edge it is loaded (the toggle looks at the
    // incoming MSB), so the stored copy is never read back.
    logic        unusedShiftMsb;
    assign unusedShiftMsb = shiftReg[7];

    // State register.
    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and cell-boundary strobes; dropping writeMode wins over everything.
    always_comb begin
        stateNext   = state;
        transfer    = 1'b0;
        cellAdvance = 1'b0;
        byteDone    = 1'b0;
        case (state)
            IDLE: begin
                if (writeMode) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (!writeMode) begin
                    stateNext = IDLE;
                end else if (cep && holdFull) begin
                    transfer  = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (!writeMode) begin
                    stateNext = IDLE;
                end else if (cep && (cellCnt == 8'd0)) begin
                    if (bitCnt == 3'd0) begin
                        byteDone = 1'b1;
                        if (holdFull) begin
                            transfer = 1'b1;
                        end else begin
                            stateNext = UNDERRUN;
                        end
                    end else begin
                        cellAdvance = 1'b1;
                    end
                end
            end
            UNDERRUN: begin
                if (!writeMode) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A write arriving as the session falls into underrun is too late and is dropped.
    assign accept = writeMode && dataWrite && (state != UNDERRUN) && (stateNext != UNDERRUN);

    // Holding register: a CPU write beats the transfer that empties it, so a
    // write on the transfer edge leaves the new byte waiting and the flag full.
    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            holdReg  <= 8'h00;
            holdFull <= 1'b0;
        end else begin
            if (accept) begin
                holdReg <= dataIn;
            end
            if (!writeMode || (state == UNDERRUN)) begin
                holdFull <= 1'b0;
            end else if (accept) begin
                holdFull <= 1'b1;
            end else if (transfer) begin
                holdFull <= 1'b0;
            end
        end
    end

    // Shift register, bit/cell counters and flux level; all frozen when cep=0.
    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            shiftReg <= 8'h00;
            bitCnt   <= 3'd0;
            cellCnt  <= 8'd0;
            wrDataR  <= 1'b0;
        end else begin
            if (transfer) begin
                shiftReg <= holdReg;
                bitCnt   <= 3'd7;
                cellCnt  <= CELL_LAST;
                wrDataR  <= wrDataR ^ holdReg[7];
            end else if (cellAdvance) begin
                shiftReg <= {shiftReg[6:0], 1'b0};
                bitCnt   <= bitCnt - 3'd1;
                cellCnt  <= CELL_LAST;
                wrDataR  <= wrDataR ^ shiftReg[6];
            end else if ((state == SHIFT) && writeMode && cep && (cellCnt != 8'd0)) begin
                cellCnt  <= cellCnt - 8'd1;
            end
        end
    end

`ifdef IWM_WR_BYTE_COUNT_EN
    logic [15:0] byteCountR;

    // Bytes completed in this session; cleared when a session opens, wraps naturally.
    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            byteCountR <= 16'h0000;
        end else if ((state == IDLE) && (stateNext == WAIT)) begin
            byteCountR <= 16'h0000;
        end else if (byteDone) begin
            byteCountR <= byteCountR + 16'd1;
        end
    end

    assign byteCount = byteCountR;
`endif

    assign wrData         = wrDataR;
    assign wrGate         = (state == SHIFT);
    assign _writeUnderrun = (state != UNDERRUN);
    assign _iwmBusy       = !holdFull;

endmodule
